// File: rtl/gauge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gauge_pkg
// Purpose  : Shared definitions for the gauge scheduler. This package holds the
//            zone encodings, the zone thresholds, the needle position defaults
//            and the per-gear speed-limit table.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package gauge_pkg;

  // Default scheduling and needle geometry.
  localparam int STEP_TICKS_DEF = 50;
  localparam int POS_MIN_DEF    = 5;
  localparam int POS_SPAN_DEF   = 20;

  // LED colour zone encoding.
  typedef logic [1:0] zone_t;
  localparam zone_t ZONE_GREEN  = 2'b00;
  localparam zone_t ZONE_YELLOW = 2'b01;
  localparam zone_t ZONE_RED    = 2'b10;

  // Zone thresholds, in units of the needle fraction q (0..POS_SPAN).
  localparam logic [4:0] ZONE_YELLOW_MIN = 5'd10;
  localparam logic [4:0] ZONE_RED_MIN    = 5'd18;

  // Result registered by the scheduler when a division completes.
  typedef struct packed {
    logic [4:0] target;
    zone_t      zone;
  } gauge_result_t;

  // Speed limit per gear. Gears 0, 6 and 7 are neutral and have no speed.
  function automatic logic [3:0] gear_limit(input logic [2:0] gear);
    logic [3:0] lim;
    lim = 4'd0;
    case (gear)
      3'd1:    lim = 4'd3;
      3'd2:    lim = 4'd5;
      3'd3:    lim = 4'd7;
      3'd4:    lim = 4'd10;
      3'd5:    lim = 4'd15;
      default: lim = 4'd0;
    endcase
    return lim;
  endfunction

  // Map the needle fraction onto the LED colour.
  function automatic zone_t zone_of(input logic [4:0] q);
    zone_t z;
    if (q >= ZONE_RED_MIN) begin
      z = ZONE_RED;
    end else if (q >= ZONE_YELLOW_MIN) begin
      z = ZONE_YELLOW;
    end else begin
      z = ZONE_GREEN;
    end
    return z;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gauge_sched_serdiv9x4.sv
`default_nettype none
// ============================================================================
// Module   : serdiv9x4
// Purpose  : Serial restoring divider with a 9-bit dividend and a 4-bit
//            divisor. It produces one quotient bit per cycle. The operands are
//            latched on start, and done pulses for one cycle exactly 9 cycles
//            later, when quotient holds the floor quotient.
// Ports    : clk            system clock
//            rst_n          asynchronous reset, active-low
//            start          load operands and begin a division
//            dividend[8:0]  numerator, sampled on start
//            divisor[3:0]   denominator, sampled on start
//            quotient[8:0]  result, valid while done is high
//            done           single-cycle completion strobe
// Revision : 1.0  initial release
// ============================================================================
module serdiv9x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] dividend,
  input  logic [3:0] divisor,
  output logic [8:0] quotient,
  output logic       done
);

  // quo_q shifts dividend bits out at the top while quotient bits enter at
  // the bottom. After 9 steps it holds only the quotient.
  logic [8:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [4:0] trial;
  logic       qbit;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    qbit   = 1'b0;
    // The remainder is always below the divisor, so 4 bits plus the incoming
    // dividend bit are enough for the trial value.
    trial  = {rem_q, quo_q[8]};

    if (start) begin
      quo_d  = dividend;
      rem_d  = 4'd0;
      dvs_d  = divisor;
      cnt_d  = 4'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = 4'(trial - {1'b0, dvs_q});
        qbit  = 1'b1;
      end else begin
        rem_d = trial[3:0];
      end
      quo_d = {quo_q[7:0], qbit};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd8) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= 9'd0;
      rem_q  <= 4'd0;
      dvs_q  <= 4'd0;
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: rtl/gauge_sched.sv
`default_nettype none
// ============================================================================
// Module   : gauge_sched
// Purpose  : Drive-state controller. It holds the speed register and applies
//            the per-gear limit. It computes the gauge needle target as
//            POS_MIN + floor(POS_SPAN*speed/max_speed) using a serial divider.
//            It ramps the needle toward that target at one unit per STEP_TICKS
//            millisecond ticks and classifies the LED colour zone.
// Ports    : clk_100mhz        system clock
//            rst_n             asynchronous reset, active-low
//            tick_1khz         single-cycle 1 kHz enable
//            accel_pulse       debounced accelerate event
//            decel_pulse       debounced decelerate event
//            gear[2:0]         synchronised gear selector
//            speed[3:0]        current speed
//            max_speed[3:0]    limit for the current gear
//            gauge_target[4:0] computed needle target
//            gauge_pos[4:0]    ramped needle position (to PWM)
//            zone[1:0]         00 green, 01 yellow, 10 red
//            settled           needle at target and scheduler idle
// Revision : 1.0  initial release
// ============================================================================
module gauge_sched
  import gauge_pkg::*;
#(
  parameter int STEP_TICKS = STEP_TICKS_DEF,
  parameter int POS_MIN    = POS_MIN_DEF,
  parameter int POS_SPAN   = POS_SPAN_DEF
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       tick_1khz,
  input  logic       accel_pulse,
  input  logic       decel_pulse,
  input  logic [2:0] gear,
  output logic [3:0] speed,
  output logic [3:0] max_speed,
  output logic [4:0] gauge_target,
  output logic [4:0] gauge_pos,
  output logic [1:0] zone,
  output logic       settled
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam int              CNT_W     = $clog2(STEP_TICKS + 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [4:0]      POS_RST   = 5'(POS_MIN);
  localparam logic [8:0]      SPAN9     = 9'(POS_SPAN);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]       gear_q, gear_d;
  logic [3:0]       speed_q, speed_d;
  logic [1:0]       state_q, state_d;
  logic             pending_q, pending_d;
  logic             bypass_q, bypass_d;
  gauge_result_t    res_q, res_d;
  logic [4:0]       pos_q, pos_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  // --------------------------------------------------------------------------
  // Speed / gear event handling
  // --------------------------------------------------------------------------
  logic [3:0] limit_cur;
  logic [3:0] limit_new;
  logic       gear_chg;
  logic       recalc;

  always_comb begin
    limit_cur = gear_limit(gear_q);
    limit_new = gear_limit(gear);
    gear_chg  = (gear != gear_q);
    gear_d    = gear_q;
    speed_d   = speed_q;

    // A gear change wins over any button event in the same cycle. A downshift
    // clamps the speed, and an upshift leaves it unchanged.
    if (gear_chg) begin
      gear_d  = gear;
      speed_d = (speed_q > limit_new) ? limit_new : speed_q;
    end else if (accel_pulse && !decel_pulse) begin
      // A limit of 0 (neutral) makes this comparison false, so accel is ignored.
      if (speed_q < limit_cur) begin
        speed_d = speed_q + 4'd1;
      end
    end else if (decel_pulse && !accel_pulse) begin
      if (speed_q != 4'd0) begin
        speed_d = speed_q - 4'd1;
      end
    end

    // A saturated button press leaves the speed unchanged, so it does not
    // trigger a recalculation.
    recalc = gear_chg || (speed_d != speed_q);
  end

  // --------------------------------------------------------------------------
  // Divider
  // --------------------------------------------------------------------------
  logic       div_start;
  logic [8:0] div_dividend;
  logic [3:0] div_divisor;
  logic [8:0] div_quotient;
  logic       div_done;

  // Operands come from the next-state values, so a division started in the
  // same cycle as an event sees the updated speed and gear.
  assign div_dividend = 9'(POS_SPAN * int'(speed_d));
  assign div_divisor  = gear_limit(gear_d);

  serdiv9x4 u_div (
    .clk      (clk_100mhz),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .done     (div_done)
  );

  // --------------------------------------------------------------------------
  // Scheduler FSM
  // --------------------------------------------------------------------------
  logic [4:0] q_frac;

  always_comb begin
    // Clamping q keeps the target inside the needle span even if a divisor
    // does not cover the full speed range.
    if (bypass_q) begin
      q_frac = 5'd0;
    end else if (div_quotient > SPAN9) begin
      q_frac = 5'(POS_SPAN);
    end else begin
      q_frac = div_quotient[4:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    bypass_d  = bypass_q;
    res_d     = res_q;
    div_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (recalc || pending_q) begin
          div_start = 1'b1;
          pending_d = 1'b0;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        // The division in flight keeps its latched operands. Any new event is
        // remembered so that it is handled after the current load.
        if (recalc) begin
          pending_d = 1'b1;
        end
        if (div_done) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        res_d.target = POS_RST + q_frac;
        res_d.zone   = zone_of(q_frac);
        if (recalc || pending_q) begin
          div_start = 1'b1;
          pending_d = 1'b0;
          state_d   = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A neutral gear skips the quotient, but the division still runs so the
    // latency is unchanged.
    if (div_start) begin
      bypass_d = (div_divisor == 4'd0);
    end
  end

  // --------------------------------------------------------------------------
  // Needle ramp. This runs independently of the scheduler FSM.
  // --------------------------------------------------------------------------
  always_comb begin
    step_cnt_d = step_cnt_q;
    pos_d      = pos_q;
    // Holding the counter at 0 while on target means every new move waits
    // a full step period before the needle moves.
    if (pos_q == res_q.target) begin
      step_cnt_d = '0;
    end else if (tick_1khz) begin
      if (step_cnt_q == STEP_LAST) begin
        step_cnt_d = '0;
        // The target is always within POS_MIN..POS_MIN+POS_SPAN, so moving
        // toward it keeps the needle in range.
        if (res_q.target > pos_q) begin
          pos_d = pos_q + 5'd1;
        end else begin
          pos_d = pos_q - 5'd1;
        end
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      // gear_q tracks the live selector during reset, so release does not
      // look like a gear change.
      gear_q      <= gear;
      speed_q     <= 4'd0;
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      bypass_q    <= 1'b0;
      res_q       <= '{target: POS_RST, zone: ZONE_GREEN};
      pos_q       <= POS_RST;
      step_cnt_q  <= '0;
    end else begin
      gear_q      <= gear_d;
      speed_q     <= speed_d;
      state_q     <= state_d;
      pending_q   <= pending_d;
      bypass_q    <= bypass_d;
      res_q       <= res_d;
      pos_q       <= pos_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign speed        = speed_q;
  assign max_speed    = gear_limit(gear_q);
  assign gauge_target = res_q.target;
  assign zone         = res_q.zone;
  assign gauge_pos    = pos_q;
  assign settled      = (pos_q == res_q.target) && (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gauge_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gauge_sched
// Purpose  : Self-checking bench for gauge_sched. It pushes the expected
//            speed, limit, target and zone into a queue, keyed by the cycle on
//            which they must appear. A monitor compares them at that cycle,
//            together with an independent needle-ramp reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_gauge_sched;

  logic       clk_100mhz  = 1'b0;
  logic       rst_n       = 1'b0;
  logic       tick_1khz   = 1'b0;
  logic       accel_pulse = 1'b0;
  logic       decel_pulse = 1'b0;
  logic [2:0] gear        = 3'd1;
  logic [3:0] speed;
  logic [3:0] max_speed;
  logic [4:0] gauge_target;
  logic [4:0] gauge_pos;
  logic [1:0] zone;
  logic       settled;

  gauge_sched dut (
    .clk_100mhz   (clk_100mhz),
    .rst_n        (rst_n),
    .tick_1khz    (tick_1khz),
    .accel_pulse  (accel_pulse),
    .decel_pulse  (decel_pulse),
    .gear         (gear),
    .speed        (speed),
    .max_speed    (max_speed),
    .gauge_target (gauge_target),
    .gauge_pos    (gauge_pos),
    .zone         (zone),
    .settled      (settled)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit tick_en = 1'b0;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // A millisecond tick every 4 clocks keeps the ramp tests short.
  initial begin
    forever begin
      @(posedge clk_100mhz);
      #1;
      tick_1khz = tick_en && (cyc % 4 == 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int         due;
    logic [3:0] spd;
    logic [3:0] mx;
    logic [4:0] tgt;
    logic [1:0] zn;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  logic [4:0] tgt_m;
  logic [4:0] m_pos;
  logic [4:0] last_pos;
  logic [4:0] last_m;
  int         m_cnt;

  task automatic push(input int due, input int spd, input int mx, input int tgt, input int zn);
    exp_t x;
    x.due = due;
    x.spd = 4'(spd);
    x.mx  = 4'(mx);
    x.tgt = 5'(tgt);
    x.zn  = 2'(zn);
    sb.push_back(x);
  endtask

  // The event is sampled on edge e. The target must still be old after edge
  // e+10 and must be new after edge e+11.
  task automatic expect_load(input int e, input int spd, input int mx,
                             input int tgt_old, input int zn_old, input int tgt, input int zn);
    push(e + 10, spd, mx, tgt_old, zn_old);
    push(e + 11, spd, mx, tgt, zn);
  endtask

  always @(negedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      tgt_m    = 5'd5;
      last_pos = 5'd5;
      last_m   = 5'd5;
    end else begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        m_e = sb.pop_front();
        check("sb_due", cyc, m_e.due);
        check("sb_speed", int'(speed), int'(m_e.spd));
        check("sb_max_speed", int'(max_speed), int'(m_e.mx));
        check("sb_gauge_target", int'(gauge_target), int'(m_e.tgt));
        check("sb_zone", int'(zone), int'(m_e.zn));
        tgt_m = m_e.tgt;
      end
      if (gauge_pos != last_pos || m_pos != last_m) begin
        check("ramp_gauge_pos", int'(gauge_pos), int'(m_pos));
      end
      last_pos = gauge_pos;
      last_m   = m_pos;
    end
  end

  // Needle reference: one unit toward the expected target per 50 ticks,
  // counting only while off target.
  always @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_pos <= 5'd5;
    end else if (m_pos == tgt_m) begin
      m_cnt <= 0;
    end else if (tick_1khz) begin
      if (m_cnt == 49) begin
        m_cnt <= 0;
        m_pos <= (tgt_m > m_pos) ? m_pos + 5'd1 : m_pos - 5'd1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic idle(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic press(input bit a, input bit d, output int e);
    @(posedge clk_100mhz);
    #1;
    accel_pulse = a;
    decel_pulse = d;
    e = cyc + 1;
    @(posedge clk_100mhz);
    #1;
    accel_pulse = 1'b0;
    decel_pulse = 1'b0;
  endtask

  task automatic set_gear(input logic [2:0] g, output int e);
    @(posedge clk_100mhz);
    #1;
    gear = g;
    e = cyc + 1;
  endtask

  task automatic wait_settled(input string name);
    int k;
    k = 0;
    while (settled !== 1'b1 && k < 8000) begin
      @(negedge clk_100mhz);
      k++;
    end
    check(name, int'(settled), 1);
  endtask

  initial begin
    int e;
    int lows;
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int e;
    int lows;

    // Reset state
    repeat (3) @(posedge clk_100mhz);
    #1;
    check("rst_speed", int'(speed), 0);
    check("rst_max_speed", int'(max_speed), 3);
    check("rst_target", int'(gauge_target), 5);
    check("rst_pos", int'(gauge_pos), 5);
    check("rst_zone", int'(zone), 0);
    check("rst_settled", int'(settled), 1);
    rst_n = 1'b1;
    idle(2);
    tick_en = 1'b1;

    // Gear 1: five accel presses, saturating at 3
    press(1, 0, e); expect_load(e, 1, 3, 5, 0, 11, 0);  idle(14);
    press(1, 0, e); expect_load(e, 2, 3, 11, 0, 18, 1); idle(14);
    press(1, 0, e); expect_load(e, 3, 3, 18, 1, 25, 2); idle(14);
    press(1, 0, e); expect_load(e, 3, 3, 25, 2, 25, 2); idle(14);
    press(1, 0, e); expect_load(e, 3, 3, 25, 2, 25, 2); idle(14);
    wait_settled("settle_full_scale");
    check("pos_full_scale", int'(gauge_pos), 25);

    // Upshift to gear 3, then decel
    set_gear(3, e); expect_load(e, 3, 7, 25, 2, 13, 0); idle(14);
    press(0, 1, e); expect_load(e, 2, 7, 13, 0, 10, 0); idle(14);
    wait_settled("settle_ramp_down");
    check("pos_ramp_down", int'(gauge_pos), 10);

    // Accelerate through gear 3
    press(1, 0, e); expect_load(e, 3, 7, 10, 0, 13, 0); idle(14);
    press(1, 0, e); expect_load(e, 4, 7, 13, 0, 16, 1); idle(14);
    press(1, 0, e); expect_load(e, 5, 7, 16, 1, 19, 1); idle(14);
    press(1, 0, e); expect_load(e, 6, 7, 19, 1, 22, 1); idle(14);
    press(1, 0, e); expect_load(e, 7, 7, 22, 1, 25, 2); idle(14);
    press(1, 0, e); expect_load(e, 7, 7, 25, 2, 25, 2); idle(14);

    // Downshift clamps the speed. Neutral ignores accel.
    set_gear(1, e); expect_load(e, 3, 3, 25, 2, 25, 2); idle(14);
    set_gear(0, e); expect_load(e, 0, 0, 25, 2, 5, 0);  idle(14);
    press(1, 0, e); expect_load(e, 0, 0, 5, 0, 5, 0);   idle(14);
    press(0, 1, e); expect_load(e, 0, 0, 5, 0, 5, 0);   idle(14);

    // Gear 2, speed 1
    set_gear(2, e); expect_load(e, 0, 5, 5, 0, 5, 0); idle(14);
    press(1, 0, e); expect_load(e, 1, 5, 5, 0, 9, 0); idle(14);
    wait_settled("settle_gear2");
    check("pos_gear2", int'(gauge_pos), 9);

    // Simultaneous accel and decel: nothing happens
    press(1, 1, e);
    lows = 0;
    repeat (14) begin
      @(negedge clk_100mhz);
      if (settled !== 1'b1) lows++;
    end
    check("both_speed", int'(speed), 1);
    check("both_no_fsm_activity", lows, 0);

    // Event 3 cycles into CALC: first result loads, then a second CALC runs
    press(1, 0, e);
    idle(1);
    press(1, 0, lows);
    check("pending_sample_edge", lows, e + 3);
    push(e + 10, 3, 5, 9, 0);
    push(e + 11, 3, 5, 13, 0);
    push(e + 21, 3, 5, 13, 0);
    push(e + 22, 3, 5, 17, 1);
    idle(25);

    // Async reset mid-ramp and mid-CALC
    idle(600);
    press(0, 1, e);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_speed", int'(speed), 0);
    check("arst_target", int'(gauge_target), 5);
    check("arst_pos", int'(gauge_pos), 5);
    check("arst_zone", int'(zone), 0);
    check("arst_settled", int'(settled), 1);
    idle(3);
    rst_n = 1'b1;
    idle(300);
    check("post_rst_target", int'(gauge_target), 5);
    check("post_rst_pos", int'(gauge_pos), 5);
    check("post_rst_max_speed", int'(max_speed), 5);

    // Fresh ramp after reset, covered by the ramp reference
    press(1, 0, e); expect_load(e, 1, 5, 5, 0, 9, 0); idle(14);
    idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
